// File: rtl/sinc3_ctrl_pkg.sv
// Shared types and constants for the sinc3 decimator controller.
package sinc3_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StRun   = 2'd2
  } state_e;

  localparam logic [1:0] MODE4 = 2'b00;
  localparam logic [1:0] MODE2 = 2'b01;
  localparam logic [1:0] MODE1 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned SETTLE_WORDS_DEFAULT = 3;

endpackage

// File: rtl/sinc3_ctrl_fifo.sv
// Two-entry output FIFO; head is always visible on dout, clr empties it.
module sinc3_ctrl_fifo
  import sinc3_ctrl_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk_adc,
  input  logic          rstn_adc,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  // When full, a push is only taken if the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_adc or negedge rstn_adc) begin
    if (!rstn_adc) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sinc3_ctrl.sv
// Sinc3 decimator controller: word_clk sync, flush/run sequencing, buffered output stream.
// Optional SINC3_CTRL_OVR_CNT_EN adds the saturating dropped-word counter ovr_cnt.
module sinc3_ctrl
  import sinc3_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_WORDS = SETTLE_WORDS_DEFAULT,
  parameter int unsigned DW           = 16
) (
  input  logic          clk_adc,
  input  logic          rstn_adc,
  input  logic          word_clk,
  input  logic [DW-1:0] data_in,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode_req,
  output logic [1:0]    mode,
  output logic          busy,
  output logic          settled,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          overrun
`ifdef SINC3_CTRL_OVR_CNT_EN
  ,
  output logic [7:0]    ovr_cnt
`endif
);

  localparam logic [3:0] LastFlush = 4'(SETTLE_WORDS - 1);

  logic       wc_s1_q, wc_s2_q, wc_s3_q;
  logic       word_tick;
  state_e     state_q;
  logic [3:0] flush_cnt_q;
  logic [1:0] mode_q;
  logic       busy_q, settled_q, overrun_q;
  logic       start_ok, push, pop, drop;
  logic       fifo_full, fifo_empty;

  always_ff @(posedge clk_adc or negedge rstn_adc) begin
    if (!rstn_adc) begin
      wc_s1_q <= 1'b0;
      wc_s2_q <= 1'b0;
      wc_s3_q <= 1'b0;
    end else begin
      wc_s1_q <= word_clk;
      wc_s2_q <= wc_s1_q;
      wc_s3_q <= wc_s2_q;
    end
  end

  assign word_tick = wc_s2_q && !wc_s3_q;

  // stop beats start; in RUN a start for the current mode is a no-op.
  always_comb begin
    start_ok = 1'b0;
    if (start && !stop) begin
      case (state_q)
        StIdle, StFlush: start_ok = 1'b1;
        StRun:           start_ok = (mode_req != mode_q);
        default:         start_ok = 1'b0;
      endcase
    end
  end

  assign pop  = dout_valid && dout_ready;
  assign push = word_tick && (state_q == StRun) && !start_ok;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk_adc or negedge rstn_adc) begin
    if (!rstn_adc) begin
      state_q     <= StIdle;
      flush_cnt_q <= 4'd0;
      mode_q      <= MODE4;
      busy_q      <= 1'b0;
      settled_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (drop) begin
        overrun_q <= 1'b1;
      end
      if (stop && (state_q != StIdle)) begin
        state_q   <= StIdle;
        busy_q    <= 1'b0;
        settled_q <= 1'b0;
      end else if (start_ok) begin
        state_q     <= StFlush;
        mode_q      <= mode_req;
        flush_cnt_q <= 4'd0;
        overrun_q   <= 1'b0;
        busy_q      <= 1'b1;
        settled_q   <= 1'b0;
      end else if ((state_q == StFlush) && word_tick) begin
        flush_cnt_q <= flush_cnt_q + 4'd1;
        if (flush_cnt_q == LastFlush) begin
          state_q   <= StRun;
          settled_q <= 1'b1;
        end
      end
    end
  end

  assign mode       = mode_q;
  assign busy       = busy_q;
  assign settled    = settled_q;
  assign overrun    = overrun_q;
  assign dout_valid = !fifo_empty;

  sinc3_ctrl_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk_adc  (clk_adc),
    .rstn_adc (rstn_adc),
    .clr      (start_ok),
    .push     (push),
    .pop      (pop),
    .din      (data_in),
    .dout     (dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef SINC3_CTRL_OVR_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk_adc or negedge rstn_adc) begin
    if (!rstn_adc) begin
      ovr_cnt_q <= 8'd0;
    end else if (start_ok) begin
      ovr_cnt_q <= 8'd0;
    end else if (drop && (ovr_cnt_q != 8'hff)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_sinc3_ctrl.sv
// Directed bench for sinc3_ctrl: flush/run sequencing, FIFO backpressure, overrun, reset.
module tb_sinc3_ctrl;

  localparam int unsigned DW = 16;

  logic          clk_adc = 1'b0;
  logic          rstn_adc;
  logic          word_clk;
  logic [DW-1:0] data_in;
  logic          start;
  logic          stop;
  logic [1:0]    mode_req;
  logic [1:0]    mode;
  logic          busy;
  logic          settled;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;
`ifdef SINC3_CTRL_OVR_CNT_EN
  logic [7:0]    ovr_cnt;
`endif

  int            errs = 0;
  int            checks = 0;
  int            valid_cycles = 0;
  logic [DW-1:0] got_q [$];

  always #5 clk_adc = ~clk_adc;

  sinc3_ctrl #(
    .SETTLE_WORDS(3),
    .DW          (DW)
  ) dut (
    .clk_adc    (clk_adc),
    .rstn_adc   (rstn_adc),
    .word_clk   (word_clk),
    .data_in    (data_in),
    .start      (start),
    .stop       (stop),
    .mode_req   (mode_req),
    .mode       (mode),
    .busy       (busy),
    .settled    (settled),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
`ifdef SINC3_CTRL_OVR_CNT_EN
    ,
    .ovr_cnt    (ovr_cnt)
`endif
  );

  // Record every word handed over on the stream and every cycle dout_valid is high.
  always @(negedge clk_adc) begin
    if (rstn_adc) begin
      if (dout_valid) valid_cycles++;
      if (dout_valid && dout_ready) got_q.push_back(dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_adc);
    #2;
  endtask

  task automatic word(input logic [DW-1:0] d);
    data_in  = d;
    word_clk = 1'b1;
    repeat (4) cyc();
    word_clk = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic do_start(input logic [1:0] m);
    mode_req = m;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  initial begin
    int bq;
    int bv;
    rstn_adc   = 1'b0;
    word_clk   = 1'b0;
    data_in    = '0;
    start      = 1'b0;
    stop       = 1'b0;
    mode_req   = 2'b00;
    dout_ready = 1'b0;
    repeat (3) cyc();
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_settled", 32'(settled), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rstn_adc = 1'b1;
    cyc();

    // Start in MODE1, three words flushed, two delivered.
    dout_ready = 1'b1;
    bq = got_q.size();
    bv = valid_cycles;
    do_start(2'b10);
    check("start_mode", 32'(mode), 32'h2);
    check("start_busy", 32'(busy), 32'h1);
    check("start_settled", 32'(settled), 32'h0);
    word(16'h1111);
    word(16'h2222);
    word(16'h3333);
    check("flush_settled", 32'(settled), 32'h1);
    check("flush_dropped", 32'(got_q.size() - bq), 32'h0);
    word(16'ha004);
    word(16'ha005);
    check("run_count", 32'(got_q.size() - bq), 32'h2);
    check("run_word4", 32'(got_q[bq]), 32'ha004);
    check("run_word5", 32'(got_q[bq+1]), 32'ha005);
    check("run_valid_cycles", 32'(valid_cycles - bv), 32'h2);

    // Backpressure: two held, third dropped.
    dout_ready = 1'b0;
    word(16'hb001);
    word(16'hb002);
    word(16'hb003);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(dout_valid), 32'h1);
    check("ovr_head", 32'(dout), 32'hb001);
`ifdef SINC3_CTRL_OVR_CNT_EN
    check("ovr_cnt_one", 32'(ovr_cnt), 32'h1);
`endif
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("ovr_second", 32'(dout), 32'hb002);
    check("ovr_second_valid", 32'(dout_valid), 32'h1);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("ovr_drained", 32'(dout_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    do_start(2'b01);
    check("ovr_cleared", 32'(overrun), 32'h0);
    check("restart_mode", 32'(mode), 32'h1);
    check("restart_settled", 32'(settled), 32'h0);
`ifdef SINC3_CTRL_OVR_CNT_EN
    check("ovr_cnt_clr", 32'(ovr_cnt), 32'h0);
`endif

    // Full FIFO with a pop coincident with the tick.
    word(16'h0e01);
    word(16'h0e02);
    word(16'h0e03);
    check("t3_settled", 32'(settled), 32'h1);
    check("t3_empty", 32'(dout_valid), 32'h0);
    word(16'hc001);
    word(16'hc002);
    check("t3_head", 32'(dout), 32'hc001);
    data_in  = 16'hc003;
    word_clk = 1'b1;
    cyc();
    cyc();
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("t3_no_ovr", 32'(overrun), 32'h0);
    check("t3_next", 32'(dout), 32'hc002);
    repeat (2) cyc();
    word_clk = 1'b0;
    repeat (4) cyc();
    check("t3_hold", 32'(dout), 32'hc002);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("t3_new", 32'(dout), 32'hc003);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("t3_drained", 32'(dout_valid), 32'h0);

    // Restart in RUN: same mode ignored, new mode reflushes.
    word(16'hd001);
    do_start(2'b01);
    check("same_settled", 32'(settled), 32'h1);
    check("same_busy", 32'(busy), 32'h1);
    check("same_keep", 32'(dout), 32'hd001);
    check("same_valid", 32'(dout_valid), 32'h1);
    do_start(2'b11);
    check("diff_mode", 32'(mode), 32'h3);
    check("diff_settled", 32'(settled), 32'h0);
    check("diff_cleared", 32'(dout_valid), 32'h0);
    dout_ready = 1'b1;
    bq = got_q.size();
    word(16'hd002);
    word(16'hd003);
    word(16'hd004);
    check("diff_flushed", 32'(got_q.size() - bq), 32'h0);
    check("diff_resettled", 32'(settled), 32'h1);
    word(16'hd005);
    check("diff_count", 32'(got_q.size() - bq), 32'h1);
    check("diff_word", 32'(got_q[bq]), 32'hd005);

    // start+stop together: stop wins, buffer stays drainable.
    dout_ready = 1'b0;
    word(16'he001);
    mode_req = 2'b00;
    start    = 1'b1;
    stop     = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_settled", 32'(settled), 32'h0);
    check("stop_mode", 32'(mode), 32'h3);
    check("stop_valid", 32'(dout_valid), 32'h1);
    check("stop_dout", 32'(dout), 32'he001);
    word(16'he002);
    check("idle_no_push", 32'(dout), 32'he001);

    // Reset pulsed mid-FLUSH.
    do_start(2'b10);
    check("t5_busy", 32'(busy), 32'h1);
    word(16'hf001);
    @(negedge clk_adc);
    rstn_adc = 1'b0;
    #1;
    check("arst_mode", 32'(mode), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_settled", 32'(settled), 32'h0);
    check("arst_valid", 32'(dout_valid), 32'h0);
    check("arst_dout", 32'(dout), 32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
    cyc();
    rstn_adc = 1'b1;
    cyc();
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
